// File: rtl/delay_line_pkg.sv
// Shared defaults for the edge timestamper and its event FIFO.
package delay_line_pkg;

  // Default timestamp width in bits.
  localparam int TS_W_DEFAULT  = 24;

  // Default event FIFO depth in entries (power of 2, >= 2).
  localparam int DEPTH_DEFAULT = 8;

  // Width of the glitch-filter qualification counter (FILT_LEN up to 15).
  localparam int FILT_CNT_W    = 4;

  // An event record is {level, timestamp}.
  function automatic int evt_width(input int ts_w);
    return ts_w + 1;
  endfunction

  localparam int EVT_W_DEFAULT = TS_W_DEFAULT + 1;

endpackage

// File: rtl/event_fifo.sv
// Event FIFO with a registered head entry and a valid/ready read side.
// A push arriving while full is accepted only if the head is popped in the
// same cycle; otherwise it is dropped and drop_o pulses.
module event_fifo
  import delay_line_pkg::*;
#(
  parameter int WIDTH = EVT_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             drop_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  logic             pop;
  logic             full;
  logic             push_ok;
  logic [PTR_W-1:0] rd_next;

  assign pop     = valid_o && ready_i;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;
  assign rd_next = rd_ptr_q + PTR_W'(1);
  assign valid_o = (count_q != '0);
  assign data_o  = head_q;

  // Next pointers, occupancy and head entry.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (pop) begin
      rd_ptr_d = rd_next;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    // The head comes from storage when an older entry remains behind it,
    // otherwise straight from the push port when the FIFO was (or is about
    // to become) empty.
    if (pop && (count_q > CNT_W'(1))) begin
      head_d = mem_q[rd_next];
    end else if (push_ok && ((count_q == '0) || (pop && (count_q == CNT_W'(1))))) begin
      head_d = push_data_i;
    end
  end

  // Control state; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Entry storage; a full-FIFO push with pop overwrites the departing head slot.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/edge_timestamper.sv
// Synchronises and glitch-filters an asynchronous input, timestamps every
// change of the filtered level and queues {level, time} events for a consumer.
module edge_timestamper
  import delay_line_pkg::*;
#(
  parameter int TS_W     = TS_W_DEFAULT,
  parameter int FILT_LEN = 4,
  parameter int DEPTH    = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            in,
  output logic            filt,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [TS_W-1:0] evt_time,
  output logic            evt_level,
  output logic            overflow
);

  localparam int                    EVT_W      = evt_width(TS_W);
  localparam logic [FILT_CNT_W-1:0] FILT_LEN_C = FILT_CNT_W'(FILT_LEN);

  logic                  sync1_q, sync2_q;
  logic                  filt_q, filt_d;
  logic [FILT_CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic                  evt_gen_q, evt_gen_d;
  logic                  overflow_q, overflow_d;

  logic                  fifo_drop;
  logic [EVT_W-1:0]      fifo_head;

  // Glitch filter: count consecutive cycles the synchronised sample has
  // disagreed with filt; once FILT_LEN cycles are counted and the sample
  // still disagrees, filt follows it. Any agreeing sample clears the count.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (filt_cnt_q == FILT_LEN_C) begin
        filt_d = ~filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_CNT_W'(1);
      end
    end
  end

  // Free-running timestamp, event strobe for the cycle after filt changes,
  // and sticky overflow.
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    evt_gen_d  = (filt_d != filt_q);
    overflow_d = overflow_q | fifo_drop;
  end

  // Synchroniser, filter, timestamp and flag registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
      ts_q       <= '0;
      evt_gen_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= in;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      ts_q       <= ts_d;
      evt_gen_q  <= evt_gen_d;
      overflow_q <= overflow_d;
    end
  end

  // Events are pushed during the first cycle that shows the new filt level,
  // carrying the timestamp of that cycle.
  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clk         (clk),
    .n_reset     (n_reset),
    .push_i      (evt_gen_q),
    .push_data_i ({filt_q, ts_q}),
    .drop_o      (fifo_drop),
    .valid_o     (evt_valid),
    .ready_i     (evt_ready),
    .data_o      (fifo_head)
  );

  assign filt      = filt_q;
  assign overflow  = overflow_q;
  assign evt_level = fifo_head[TS_W];
  assign evt_time  = fifo_head[TS_W-1:0];

endmodule

// File: tb/tb_edge_timestamper.sv
// Directed bench for edge_timestamper: a default instance (TS_W=24,
// FILT_LEN=4, DEPTH=8) and a small instance (TS_W=4, FILT_LEN=1, DEPTH=4)
// for timestamp wrap. cyc counts clock edges since reset release, so
// "cycle k" is the period just after edge k.
module tb_edge_timestamper;

  logic        clk;
  logic        n_reset;
  logic        sig_in;
  logic        filt;
  logic        evt_valid;
  logic        evt_ready;
  logic [23:0] evt_time;
  logic        evt_level;
  logic        overflow;

  logic        in_w;
  logic        filt_w;
  logic        valid_w;
  logic        ready_w;
  logic [3:0]  time_w;
  logic        level_w;
  logic        ovf_w;

  int cyc;
  int pass_cnt;
  int total_cnt;

  edge_timestamper #(
    .TS_W     (24),
    .FILT_LEN (4),
    .DEPTH    (8)
  ) u_dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .in        (sig_in),
    .filt      (filt),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_time  (evt_time),
    .evt_level (evt_level),
    .overflow  (overflow)
  );

  edge_timestamper #(
    .TS_W     (4),
    .FILT_LEN (1),
    .DEPTH    (4)
  ) u_wrap (
    .clk       (clk),
    .n_reset   (n_reset),
    .in        (in_w),
    .filt      (filt_w),
    .evt_valid (valid_w),
    .evt_ready (ready_w),
    .evt_time  (time_w),
    .evt_level (level_w),
    .overflow  (ovf_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!n_reset) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after edge n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic in_lvl);
    n_reset   = 1'b0;
    sig_in    = in_lvl;
    evt_ready = 1'b0;
    in_w      = 1'b0;
    ready_w   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_reset;
    n_reset   = 1'b0;
    sig_in    = 1'b0;
    evt_ready = 1'b0;
    in_w      = 1'b0;
    ready_w   = 1'b0;
    #3;
    total_cnt++;
    if ({filt, evt_valid, evt_time, evt_level, overflow} !== 28'h0) begin
      $display("FAIL reset_main: got %0h required 0", {filt, evt_valid, evt_time, evt_level, overflow});
    end else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({filt_w, valid_w, time_w, level_w, ovf_w} !== 8'h0) begin
      $display("FAIL reset_wrap: got %0h required 0", {filt_w, valid_w, time_w, level_w, ovf_w});
    end else pass_cnt++;
  endtask

  task automatic test_basic_edge;
    do_reset(1'b0);
    goto(9);
    sig_in = 1'b1;
    goto(15);
    total_cnt++;
    if (filt !== 1'b0) $display("FAIL basic_filt_early: got %0b required 0", filt);
    else pass_cnt++;
    goto(16);
    total_cnt++;
    if ({filt, evt_valid} !== 2'b10) $display("FAIL basic_filt_rise: got filt/valid %b required 10", {filt, evt_valid});
    else pass_cnt++;
    goto(17);
    total_cnt++;
    if ({evt_valid, evt_level, evt_time, overflow} !== {1'b1, 1'b1, 24'd16, 1'b0}) begin
      $display("FAIL basic_event: got valid=%0b level=%0b time=%0d ovf=%0b required 1 1 16 0",
               evt_valid, evt_level, evt_time, overflow);
    end else pass_cnt++;
    $display("evt pop time=%0d level=%0b", evt_time, evt_level);
    evt_ready = 1'b1;
    goto(18);
    evt_ready = 1'b0;
    total_cnt++;
    if (evt_valid !== 1'b0) $display("FAIL basic_pop_empty: got %0b required 0", evt_valid);
    else pass_cnt++;
    goto(20);
    sig_in = 1'b0;
    goto(28);
    total_cnt++;
    if ({evt_valid, evt_level, evt_time} !== {1'b1, 1'b0, 24'd27}) begin
      $display("FAIL basic_fall_event: got valid=%0b level=%0b time=%0d required 1 0 27",
               evt_valid, evt_level, evt_time);
    end else pass_cnt++;
  endtask

  task automatic test_glitch;
    do_reset(1'b0);
    goto(9);
    sig_in = 1'b1;
    goto(12);
    sig_in = 1'b0;
    for (int c = 10; c <= 30; c++) begin
      goto(c);
      total_cnt++;
      if ({filt, evt_valid} !== 2'b00) $display("FAIL glitch_c%0d: got filt/valid %b required 00", c, {filt, evt_valid});
      else pass_cnt++;
    end
  endtask

  task automatic test_in_high_at_release;
    do_reset(1'b1);
    goto(6);
    total_cnt++;
    if (filt !== 1'b0) $display("FAIL release_filt_early: got %0b required 0", filt);
    else pass_cnt++;
    goto(7);
    total_cnt++;
    if (filt !== 1'b1) $display("FAIL release_filt_rise: got %0b required 1", filt);
    else pass_cnt++;
    goto(8);
    total_cnt++;
    if ({evt_valid, evt_level, evt_time} !== {1'b1, 1'b1, 24'd7}) begin
      $display("FAIL release_event: got valid=%0b level=%0b time=%0d required 1 1 7",
               evt_valid, evt_level, evt_time);
    end else pass_cnt++;
  endtask

  task automatic test_overflow;
    int exp_t;
    logic exp_l;
    do_reset(1'b0);
    for (int k = 0; k < 9; k++) begin
      goto(9 + 8 * k);
      sig_in = ~sig_in;
    end
    goto(80);
    total_cnt++;
    if ({overflow, evt_valid, evt_time} !== {1'b0, 1'b1, 24'd16}) begin
      $display("FAIL ovf_before: got ovf=%0b valid=%0b time=%0d required 0 1 16", overflow, evt_valid, evt_time);
    end else pass_cnt++;
    goto(81);
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_set: got %0b required 1", overflow);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      goto(84 + i);
      exp_t = 16 + 8 * i;
      exp_l = ((i % 2) == 0);
      total_cnt++;
      if ({evt_valid, evt_level, evt_time} !== {1'b1, exp_l, 24'(exp_t)}) begin
        $display("FAIL ovf_order_%0d: got valid=%0b level=%0b time=%0d required 1 %0b %0d",
                 i, evt_valid, evt_level, evt_time, exp_l, exp_t);
      end else pass_cnt++;
      $display("evt pop time=%0d level=%0b", evt_time, evt_level);
      evt_ready = 1'b1;
    end
    goto(92);
    evt_ready = 1'b0;
    total_cnt++;
    if ({evt_valid, overflow} !== 2'b01) $display("FAIL ovf_drained: got valid/ovf %b required 01", {evt_valid, overflow});
    else pass_cnt++;
    #2;
    n_reset = 1'b0;
    #1;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %0b required 0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_full_push_pop;
    int exp_t;
    logic exp_l;
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) begin
      goto(9 + 8 * k);
      sig_in = ~sig_in;
    end
    goto(81);
    sig_in = ~sig_in;
    goto(88);
    total_cnt++;
    if ({filt, overflow, evt_time} !== {1'b1, 1'b0, 24'd16}) begin
      $display("FAIL full_before: got filt=%0b ovf=%0b time=%0d required 1 0 16", filt, overflow, evt_time);
    end else pass_cnt++;
    evt_ready = 1'b1;
    goto(89);
    evt_ready = 1'b0;
    total_cnt++;
    if ({overflow, evt_valid, evt_time} !== {1'b0, 1'b1, 24'd24}) begin
      $display("FAIL full_pushpop: got ovf=%0b valid=%0b time=%0d required 0 1 24", overflow, evt_valid, evt_time);
    end else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      goto(90 + i);
      exp_t = (i < 7) ? (24 + 8 * i) : 88;
      exp_l = (i < 7) ? (((i + 1) % 2) == 0) : 1'b1;
      total_cnt++;
      if ({evt_valid, evt_level, evt_time} !== {1'b1, exp_l, 24'(exp_t)}) begin
        $display("FAIL full_order_%0d: got valid=%0b level=%0b time=%0d required 1 %0b %0d",
                 i, evt_valid, evt_level, evt_time, exp_l, exp_t);
      end else pass_cnt++;
      $display("evt pop time=%0d level=%0b", evt_time, evt_level);
      evt_ready = 1'b1;
    end
    goto(98);
    evt_ready = 1'b0;
    total_cnt++;
    if ({evt_valid, overflow} !== 2'b00) $display("FAIL full_drained: got valid/ovf %b required 00", {evt_valid, overflow});
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    do_reset(1'b0);
    goto(10);
    in_w = 1'b1;
    goto(13);
    in_w = 1'b0;
    goto(14);
    total_cnt++;
    if (filt_w !== 1'b1) $display("FAIL wrap_filt_rise: got %0b required 1", filt_w);
    else pass_cnt++;
    goto(15);
    total_cnt++;
    if ({valid_w, level_w, time_w} !== {1'b1, 1'b1, 4'd14}) begin
      $display("FAIL wrap_first: got valid=%0b level=%0b time=%0d required 1 1 14", valid_w, level_w, time_w);
    end else pass_cnt++;
    $display("wrap evt pop time=%0d level=%0b", time_w, level_w);
    ready_w = 1'b1;
    goto(16);
    ready_w = 1'b0;
    total_cnt++;
    if (valid_w !== 1'b0) $display("FAIL wrap_pop: got %0b required 0", valid_w);
    else pass_cnt++;
    goto(18);
    total_cnt++;
    if ({valid_w, level_w, time_w, ovf_w} !== {1'b1, 1'b0, 4'd1, 1'b0}) begin
      $display("FAIL wrap_second: got valid=%0b level=%0b time=%0d ovf=%0b required 1 0 1 0",
               valid_w, level_w, time_w, ovf_w);
    end else pass_cnt++;
  endtask

  task automatic test_reset_flush;
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      goto(9 + 8 * k);
      sig_in = ~sig_in;
    end
    goto(40);
    total_cnt++;
    if ({evt_valid, evt_time} !== {1'b1, 24'd16}) begin
      $display("FAIL flush_before: got valid=%0b time=%0d required 1 16", evt_valid, evt_time);
    end else pass_cnt++;
    #2;
    n_reset = 1'b0;
    sig_in  = 1'b0;
    #1;
    total_cnt++;
    if ({evt_valid, evt_level, evt_time, filt} !== 27'h0) begin
      $display("FAIL flush_in_reset: got valid=%0b level=%0b time=%0d filt=%0b required 0 0 0 0",
               evt_valid, evt_level, evt_time, filt);
    end else pass_cnt++;
    do_reset(1'b0);
    for (int c = 1; c <= 30; c++) begin
      goto(c);
      total_cnt++;
      if (evt_valid !== 1'b0) $display("FAIL flush_after_c%0d: got %0b required 0", c, evt_valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic_edge();
    test_glitch();
    test_in_high_at_release();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/edge_timestamper.md
EDGE_TIMESTAMPER -- requirements
Module: edge_timestamper

Interface
REQ-001 Parameter TS_W, default 24, SHALL set the timestamp width in bits.
REQ-002 Parameter FILT_LEN, default 4, SHALL set the glitch-filter qualification length in cycles (range 1..15).
REQ-003 Parameter DEPTH, default 8, SHALL set the event FIFO depth in entries (power of 2, at least 2).
REQ-004 clk  input  1  SHALL be the single clock (PLL output).
REQ-005 n_reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 in  input  1  SHALL be the raw asynchronous input signal.
REQ-007 filt  output  1  SHALL be the synchronised, glitch-filtered level.
REQ-008 evt_valid  output  1  SHALL indicate that an event is present at the FIFO head.
REQ-009 evt_ready  input  1  SHALL be the consumer (delay_line) acceptance strobe.
REQ-010 evt_time  output  TS_W  SHALL be the timestamp of the head event.
REQ-011 evt_level  output  1  SHALL be the new filt level of the head event.
REQ-012 overflow  output  1  SHALL be a sticky flag set when an event is dropped.

Function
REQ-013 in SHALL pass through a 2-flop synchroniser before any other use.
REQ-014 filt SHALL change only after the synchronised sample differs from filt for FILT_LEN consecutive cycles; any intervening matching sample SHALL restart the qualification count.
REQ-015 Latency from an in transition, sampled at edge N, to the filt update SHALL be exactly 2+FILT_LEN cycles.
REQ-016 A free-running TS_W-bit counter SHALL increment every cycle and wrap from all-ones to 0 without flagging.
REQ-017 On each cycle in which filt changes, one event SHALL be generated: evt_time = counter value in that cycle; evt_level = new filt value.
REQ-018 Events SHALL be written to a DEPTH-entry FIFO in generation order.
REQ-019 evt_valid SHALL be high exactly when the FIFO is non-empty; evt_time and evt_level SHALL show the head entry.
REQ-020 A pop SHALL occur on a cycle with evt_valid && evt_ready; evt_ready while empty SHALL be ignored.
REQ-021 evt_time and evt_level SHALL remain stable while evt_valid is high and evt_ready is low.
REQ-022 An event written into an empty FIFO SHALL appear on evt_valid one cycle after generation.
REQ-023 An event generated while the FIFO is full with no pop in the same cycle SHALL be dropped, and overflow SHALL be set.
REQ-024 An event generated while the FIFO is full and a pop occurs in the same cycle SHALL be accepted, with no overflow.
REQ-025 A simultaneous push and pop at any occupancy SHALL leave occupancy unchanged.
REQ-026 overflow SHALL remain set until reset.

Reset
REQ-027 While n_reset is low: sync flops = 0, filt = 0, filter count = 0, counter = 0, FIFO empty, evt_valid = 0, overflow = 0, evt_time = 0, evt_level = 0.
REQ-028 Reset assertion mid-operation SHALL discard all queued events immediately, with no partial pop visible.
REQ-029 If in is high at reset release, a rising event SHALL be generated 2+FILT_LEN cycles after the first clock edge following release.

Structure
REQ-030 Package delay_line_pkg SHALL hold the TS_W default, the FIFO DEPTH default, and the event record width (TS_W+1).
REQ-031 Storage SHALL be one sub-module, event_fifo (parameterised width/depth, valid/ready read side, registered head).
REQ-032 Synchroniser, filter, and counter SHALL reside in edge_timestamper.

Verification
REQ-033 FILT_LEN=4; in 0->1 sampled at cycle 10, held -> filt rises at cycle 16; one event {time=16, level=1}; evt_valid at cycle 17.
REQ-034 in 3-cycle high glitch at FILT_LEN=4 -> filt stays 0; no event; evt_valid stays 0.
REQ-035 evt_ready=0; 9 qualified edges at DEPTH=8 -> 8 events queued in order; 9th dropped; overflow=1 until n_reset pulse.
REQ-036 FIFO full, evt_ready=1 on the same cycle as a new edge -> head popped, new event accepted, occupancy stays 8, overflow=0.
REQ-037 TS_W=4; edges at counter values 14 and 17 -> evt_time 14 then 1.
REQ-038 n_reset low with 3 events queued -> evt_valid=0 within the reset; after release with in=0, no events.
